otbn_pq_ntt_sequencer: RTL and testbench

- Address/twiddle-index sequencer for the PQ butterfly datapath.
- On start, walks all NTT layers for N = 2^log_n coefficients. Each step emits one butterfly command: coefficient index pair, twiddle index and op (Cooley-Tukey forward or Gentleman-Sande inverse).
- Sits between the PQ controller and the butterfly ALU / WDR word-select logic, and replaces software loop management of M/J2/J/Idx0/Idx1.

---
 rtl/otbn_pq_ntt_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_otbn_pq_ntt_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/otbn_pq_ntt_sequencer.sv
// otbn_pq_ntt_sequencer: walks every NTT layer for N = 2^log_n and emits one
// butterfly command (idx0, idx1, twiddle index, CT/GS op) per handshake.
// Ports: clk_i/rst_i (async, active high); start_i/inverse_i/log_n_i request;
//   abort_i cancels. busy_o, done_o and err_o report status. bfly_valid_o,
//   bfly_ready_i, bfly_idx0_o, bfly_idx1_o, bfly_tw_idx_o and bfly_inv_o form
//   the command; layer_o and layer_last_o give layer position.
// Optional macro OTBN_PQ_SEQ_SCALE_EN adds bfly_scale_o and a Scale pass of
//   N commands after the last inverse (GS) layer.
module otbn_pq_ntt_sequencer #(
  parameter int LogNMax = 8,
  parameter int LayerW  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               inverse_i,
  input  logic [LayerW-1:0]  log_n_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               bfly_valid_o,
  input  logic               bfly_ready_i,
  output logic [LogNMax-1:0] bfly_idx0_o,
  output logic [LogNMax-1:0] bfly_idx1_o,
  output logic [LogNMax-1:0] bfly_tw_idx_o,
  output logic               bfly_inv_o,
`ifdef OTBN_PQ_SEQ_SCALE_EN
  output logic               bfly_scale_o,
`endif
  output logic [LayerW-1:0]  layer_o,
  output logic               layer_last_o
);

  // One spare bit so that 2*len == N is representable.
  localparam int CW = LogNMax + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
`ifdef OTBN_PQ_SEQ_SCALE_EN
    StScale,
`endif
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic              inv_q, inv_d;
  logic              err_q, err_d;
  logic [LayerW-1:0] log_n_q, log_n_d;
  logic [LayerW-1:0] layer_q, layer_d;
  logic [CW-1:0]     n_q, n_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     tw_q, tw_d;
  logic [CW-1:0]     grp_q, grp_d;
  logic [CW-1:0]     j_q, j_d;

  logic in_run, in_scale, hs, legal;
  logic grp_end, lay_end, last_layer;

  assign in_run = (state_q == StRun);
`ifdef OTBN_PQ_SEQ_SCALE_EN
  assign in_scale = (state_q == StScale);
`else
  assign in_scale = 1'b0;
`endif

  assign hs    = bfly_valid_o && bfly_ready_i;
  assign legal = (log_n_i >= LayerW'(1)) &&
                 (log_n_i <= LayerW'(LogNMax));

  assign grp_end    = (j_q == len_q - CW'(1));
  assign lay_end    = grp_end && ((grp_q + (len_q << 1)) == n_q);
  assign last_layer = (layer_q == log_n_q - LayerW'(1));

  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    err_d   = err_q;
    log_n_d = log_n_q;
    layer_d = layer_q;
    n_d     = n_q;
    len_d   = len_q;
    tw_d    = tw_q;
    grp_d   = grp_q;
    j_d     = j_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (legal) begin
            state_d = StRun;
            err_d   = 1'b0;
            inv_d   = inverse_i;
            log_n_d = log_n_i;
            n_d     = CW'(1) << log_n_i;
            grp_d   = '0;
            j_d     = '0;
            layer_d = '0;
            if (inverse_i) begin
              len_d = CW'(1);
              tw_d  = (CW'(1) << log_n_i) - CW'(1);
            end else begin
              len_d = CW'(1) << (log_n_i - LayerW'(1));
              tw_d  = CW'(1);
            end
          end else begin
            state_d = StFin;
            err_d   = 1'b1;
          end
        end
      end
      StRun: begin
        if (hs) begin
          if (grp_end) begin
            j_d  = '0;
            tw_d = inv_q ? tw_q - CW'(1) : tw_q + CW'(1);
            if (lay_end) begin
              grp_d   = '0;
              layer_d = layer_q + LayerW'(1);
              len_d   = inv_q ? len_q << 1 : len_q >> 1;
              if (last_layer) begin
`ifdef OTBN_PQ_SEQ_SCALE_EN
                state_d = inv_q ? StScale : StFin;
`else
                state_d = StFin;
`endif
              end
            end else begin
              grp_d = grp_q + (len_q << 1);
            end
          end else begin
            j_d = j_q + CW'(1);
          end
        end
      end
`ifdef OTBN_PQ_SEQ_SCALE_EN
      // j_q walks 0..N-1; layer_q already equals log_n here.
      StScale: begin
        if (hs) begin
          if (j_q == n_q - CW'(1)) state_d = StFin;
          else j_d = j_q + CW'(1);
        end
      end
`endif
      StFin: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // Abort beats handshake and start.
    if (abort_i) begin
      state_d = StIdle;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
      log_n_q <= '0;
      layer_q <= '0;
      n_q     <= '0;
      len_q   <= '0;
      tw_q    <= '0;
      grp_q   <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
      log_n_q <= log_n_d;
      layer_q <= layer_d;
      n_q     <= n_d;
      len_q   <= len_d;
      tw_q    <= tw_d;
      grp_q   <= grp_d;
      j_q     <= j_d;
    end
  end

  assign busy_o       = in_run || in_scale;
  assign done_o       = (state_q == StFin);
  assign err_o        = (state_q == StFin) && err_q;
  assign bfly_valid_o = in_run || in_scale;
  assign bfly_inv_o   = bfly_valid_o && inv_q;
  assign layer_o      = bfly_valid_o ? layer_q : '0;

  // Command fields are forced to zero outside Run/Scale.
  always_comb begin
    bfly_idx0_o   = '0;
    bfly_idx1_o   = '0;
    bfly_tw_idx_o = '0;
    layer_last_o  = 1'b0;
    if (in_run) begin
      bfly_idx0_o   = LogNMax'(grp_q + j_q);
      bfly_idx1_o   = LogNMax'(grp_q + j_q + len_q);
      bfly_tw_idx_o = LogNMax'(tw_q);
      layer_last_o  = lay_end;
    end else if (in_scale) begin
      bfly_idx0_o  = LogNMax'(j_q);
      bfly_idx1_o  = LogNMax'(j_q);
      layer_last_o = (j_q == n_q - CW'(1));
    end
  end

`ifdef OTBN_PQ_SEQ_SCALE_EN
  assign bfly_scale_o = in_scale;
`endif

endmodule

// File: tb/tb_otbn_pq_ntt_sequencer.sv
// tb_otbn_pq_ntt_sequencer: directed bench for the NTT command sequencer.
// Drives forward/inverse runs, backpressure, abort, illegal sizes and reset.
module tb_otbn_pq_ntt_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       inverse_i = 1'b0;
  logic [3:0] log_n_i = '0;
  logic       abort_i = 1'b0;
  logic       bfly_ready_i = 1'b0;
  logic       busy_o, done_o, err_o, bfly_valid_o;
  logic [7:0] bfly_idx0_o, bfly_idx1_o, bfly_tw_idx_o;
  logic       bfly_inv_o, layer_last_o;
  logic [3:0] layer_o;
`ifdef OTBN_PQ_SEQ_SCALE_EN
  logic       bfly_scale_o;
`endif

  int npass = 0;
  int ntotal = 0;

  otbn_pq_ntt_sequencer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .inverse_i     (inverse_i),
    .log_n_i       (log_n_i),
    .abort_i       (abort_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .bfly_valid_o  (bfly_valid_o),
    .bfly_ready_i  (bfly_ready_i),
    .bfly_idx0_o   (bfly_idx0_o),
    .bfly_idx1_o   (bfly_idx1_o),
    .bfly_tw_idx_o (bfly_tw_idx_o),
    .bfly_inv_o    (bfly_inv_o),
`ifdef OTBN_PQ_SEQ_SCALE_EN
    .bfly_scale_o  (bfly_scale_o),
`endif
    .layer_o       (layer_o),
    .layer_last_o  (layer_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // {valid, idx0, idx1, tw, inv, last, layer}
  task automatic expect_cmd(input string tag, input logic [7:0] i0,
                            input logic [7:0] i1, input logic [7:0] tw,
                            input logic inv, input logic last,
                            input logic [3:0] lay);
    chk(tag, {bfly_valid_o, bfly_idx0_o, bfly_idx1_o, bfly_tw_idx_o,
              bfly_inv_o, layer_last_o, layer_o},
             {1'b1, i0, i1, tw, inv, last, lay});
    tick();
  endtask

  task automatic start_op(input logic inv, input logic [3:0] ln);
    start_i = 1'b1;
    inverse_i = inv;
    log_n_i = ln;
    tick();
    start_i = 1'b0;
  endtask

  logic [23:0] model[$];
  logic [23:0] cur, prev, last_cmd;
  logic        prev_stall, done_seen;
  int          hs_cnt, bad_cmd, bad_stall, k;

  initial begin
    tick();
    chk("reset_outs", {busy_o, done_o, err_o, bfly_valid_o, bfly_idx0_o,
                       bfly_idx1_o, bfly_tw_idx_o, bfly_inv_o, layer_o,
                       layer_last_o}, '0);
    rst_i = 1'b0;
    tick();

    // Forward, N = 4
    bfly_ready_i = 1'b1;
    start_op(1'b0, 4'd2);
    chk("fwd_busy", busy_o, 1);
    expect_cmd("fwd_c0", 8'd0, 8'd2, 8'd1, 1'b0, 1'b0, 4'd0);
    expect_cmd("fwd_c1", 8'd1, 8'd3, 8'd1, 1'b0, 1'b1, 4'd0);
    expect_cmd("fwd_c2", 8'd0, 8'd1, 8'd2, 1'b0, 1'b0, 4'd1);
    expect_cmd("fwd_c3", 8'd2, 8'd3, 8'd3, 1'b0, 1'b1, 4'd1);
    chk("fwd_done", {done_o, err_o, busy_o, bfly_valid_o}, 4'b1000);
    tick();
    chk("fwd_done_gone", {done_o, busy_o, bfly_valid_o}, 3'b000);

    // Inverse, N = 4
    start_op(1'b1, 4'd2);
    expect_cmd("inv_c0", 8'd0, 8'd1, 8'd3, 1'b1, 1'b0, 4'd0);
    expect_cmd("inv_c1", 8'd2, 8'd3, 8'd2, 1'b1, 1'b1, 4'd0);
    expect_cmd("inv_c2", 8'd0, 8'd2, 8'd1, 1'b1, 1'b0, 4'd1);
    expect_cmd("inv_c3", 8'd1, 8'd3, 8'd1, 1'b1, 1'b1, 4'd1);
`ifdef OTBN_PQ_SEQ_SCALE_EN
    for (int i = 0; i < 4; i++) begin
      chk("inv_scale_flag", bfly_scale_o, 1);
      expect_cmd("inv_scale", 8'(i), 8'(i), 8'd0, 1'b1, i == 3, 4'd2);
    end
`endif
    chk("inv_done", {done_o, err_o, bfly_valid_o}, 3'b100);
    tick();

    // Forward, N = 256, random backpressure, against a textbook loop model
    k = 1;
    for (int len = 128; len >= 1; len = len / 2) begin
      for (int s = 0; s < 256; s += 2 * len) begin
        for (int j = s; j < s + len; j++)
          model.push_back({8'(j), 8'(j + len), 8'(k)});
        k++;
      end
    end
    start_op(1'b0, 4'd8);
    hs_cnt = 0; bad_cmd = 0; bad_stall = 0;
    prev_stall = 1'b0; done_seen = 1'b0; prev = '0; last_cmd = '0;
    for (int cyc = 0; cyc < 5000 && !done_seen; cyc++) begin
      cur = {bfly_idx0_o, bfly_idx1_o, bfly_tw_idx_o};
      if (prev_stall && (cur !== prev || !bfly_valid_o)) bad_stall++;
      if (done_o) begin
        done_seen = 1'b1;
      end else begin
        bfly_ready_i = 1'($urandom_range(0, 1));
        if (bfly_valid_o && bfly_ready_i) begin
          if (hs_cnt >= model.size() || cur !== model[hs_cnt]) bad_cmd++;
          hs_cnt++;
          last_cmd = cur;
        end
        prev_stall = bfly_valid_o && !bfly_ready_i;
        prev = cur;
        tick();
      end
    end
    bfly_ready_i = 1'b1;
    chk("big_done_seen", done_seen, 1);
    chk("big_hs_count", hs_cnt, 1024);
    chk("big_cmd_errors", bad_cmd, 0);
    chk("big_stall_errors", bad_stall, 0);
    chk("big_last_cmd", last_cmd, {8'd254, 8'd255, 8'd255});
    tick();

    // Abort after 3 handshakes of N = 8; abort beats the 4th handshake
    start_op(1'b0, 4'd3);
    expect_cmd("ab_c0", 8'd0, 8'd4, 8'd1, 1'b0, 1'b0, 4'd0);
    expect_cmd("ab_c1", 8'd1, 8'd5, 8'd1, 1'b0, 1'b0, 4'd0);
    expect_cmd("ab_c2", 8'd2, 8'd6, 8'd1, 1'b0, 1'b0, 4'd0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("ab_idle", {bfly_valid_o, busy_o, done_o}, 3'b000);
    tick();
    chk("ab_no_done", {bfly_valid_o, busy_o, done_o}, 3'b000);
    start_op(1'b0, 4'd3);
    expect_cmd("ab_restart", 8'd0, 8'd4, 8'd1, 1'b0, 1'b0, 4'd0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    // Illegal sizes
    start_op(1'b0, 4'd0);
    chk("err0_pulse", {done_o, err_o, bfly_valid_o, busy_o}, 4'b1100);
    tick();
    chk("err0_clear", {done_o, err_o, bfly_valid_o, busy_o}, 4'b0000);
    start_op(1'b1, 4'd9);
    chk("err9_pulse", {done_o, err_o, bfly_valid_o, busy_o}, 4'b1100);
    tick();
    chk("err9_clear", {done_o, err_o, bfly_valid_o, busy_o}, 4'b0000);

    // Asynchronous reset mid-run
    start_op(1'b0, 4'd3);
    tick();
    chk("rst_pre_valid", bfly_valid_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async", {busy_o, done_o, err_o, bfly_valid_o, bfly_idx0_o,
                      bfly_idx1_o, bfly_tw_idx_o, bfly_inv_o, layer_o,
                      layer_last_o}, '0);
    tick();
    rst_i = 1'b0;
    tick();
    start_op(1'b0, 4'd3);
    expect_cmd("rst_c0", 8'd0, 8'd4, 8'd1, 1'b0, 1'b0, 4'd0);
    expect_cmd("rst_c1", 8'd1, 8'd5, 8'd1, 1'b0, 1'b0, 4'd0);
    done_seen = 1'b0;
    hs_cnt = 2;
    for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
      if (done_o) done_seen = 1'b1;
      else begin
        if (bfly_valid_o) hs_cnt++;
        tick();
      end
    end
    chk("rst_run_done", done_seen, 1);
    chk("rst_run_count", hs_cnt, 12);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
